// File: rtl/rv_control_fsm_if.sv
// Control bundle between the RV32I multi-cycle controller and its datapath/memory.
// Latency: none, plain wires; the controller owns every output field.
// Backpressure: none; memory answers after a fixed MEM_READ_LATENCY.
interface rv_control_fsm_if;
  logic [31:0] mem_read_data;
  logic        branch_taken;
  logic [31:0] instr;
  logic        mem_addr_sel;
  logic        mem_write;
  logic        reg_write;
  logic        pc_write;
  logic [1:0]  pc_sel;
  logic [2:0]  imm_sel;
  logic        alu_src_a;
  logic        alu_src_b;
  logic [1:0]  alu_sub_sel;
  logic        alu_force_add;
  logic [1:0]  rdv_sel;
  logic [31:0] instret;
  logic        halt;

  // Controller side.
  modport master (
    input  mem_read_data, branch_taken,
    output instr, mem_addr_sel, mem_write, reg_write, pc_write, pc_sel, imm_sel,
           alu_src_a, alu_src_b, alu_sub_sel, alu_force_add, rdv_sel, instret, halt
  );

  // Datapath / memory side.
  modport slave (
    output mem_read_data, branch_taken,
    input  instr, mem_addr_sel, mem_write, reg_write, pc_write, pc_sel, imm_sel,
           alu_src_a, alu_src_b, alu_sub_sel, alu_force_add, rdv_sel, instret, halt
  );
endinterface

// File: rtl/rv_control_fsm.sv
// Multi-cycle RV32I controller: fetch/decode/execute/mem/writeback over one memory port.
// Latency: branch L+3, ALU/LUI/AUIPC/JAL/JALR/store L+4, load 2L+5 cycles (L = MEM_READ_LATENCY).
// Backpressure: none; memory reads complete after a fixed L cycles, tracked by a wait counter.
module rv_control_fsm #(
  parameter int unsigned MEM_READ_LATENCY = 1
) (
  input logic              clk,
  input logic              reset,
  rv_control_fsm_if.master bus
);
  localparam logic [1:0] WAIT_INIT = 2'(MEM_READ_LATENCY - 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH, S_FETCH_WAIT, S_DECODE, S_EXECUTE, S_MEM, S_MEM_WAIT, S_WRITEBACK, S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic [1:0]  wait_q, wait_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       rd_nonzero;
  assign opcode     = instr_q[6:0];
  assign funct3     = instr_q[14:12];
  assign rd_nonzero = |instr_q[11:7];

  logic       legal;
  logic [1:0] f3_sub_sel;
  logic [1:0] ex_sub_sel;
  logic [2:0] ex_imm_sel;
  logic       ex_src_a, ex_src_b, ex_force_add;

  logic       mem_addr_sel, mem_write, reg_write, pc_write, halt;
  logic [1:0] pc_sel, alu_sub_sel, rdv_sel;
  logic [2:0] imm_sel;
  logic       alu_src_a, alu_src_b, alu_force_add;

  // ALU/immediate selects implied by the opcode; held from EXECUTE until the instruction retires.
  always_comb begin
    case (funct3)
      3'b001, 3'b101: f3_sub_sel = 2'b10;
      3'b010, 3'b011: f3_sub_sel = 2'b01;
      default:        f3_sub_sel = 2'b00;
    endcase
    legal        = 1'b1;
    ex_sub_sel   = 2'b00;
    ex_imm_sel   = 3'b000;
    ex_src_a     = 1'b0;
    ex_src_b     = 1'b0;
    ex_force_add = 1'b0;
    case (opcode)
      OPC_OP:     ex_sub_sel = f3_sub_sel;
      OPC_OPIMM: begin
        ex_sub_sel = f3_sub_sel;
        ex_src_b   = 1'b1;
        ex_imm_sel = (f3_sub_sel == 2'b10) ? 3'b001 : 3'b000;
      end
      OPC_LOAD: begin
        ex_force_add = 1'b1;
        ex_src_b     = 1'b1;
      end
      OPC_STORE: begin
        ex_force_add = 1'b1;
        ex_src_b     = 1'b1;
        ex_imm_sel   = 3'b101;
      end
      OPC_AUIPC: begin
        ex_src_a     = 1'b1;
        ex_src_b     = 1'b1;
        ex_imm_sel   = 3'b011;
        ex_force_add = 1'b1;
      end
      OPC_JALR: begin
        ex_force_add = 1'b1;
        ex_src_b     = 1'b1;
      end
      OPC_BRANCH: begin
        ex_sub_sel = 2'b01;
        ex_imm_sel = 3'b100;
      end
      OPC_LUI, OPC_JAL: legal = 1'b1;
      default:          legal = 1'b0;  // includes SYSTEM (ECALL/EBREAK)
    endcase
  end

  // Next-state sequencing and Moore outputs (pc_sel in a branch EXECUTE follows branch_taken).
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instret_d     = instret_q;
    wait_d        = wait_q;
    mem_addr_sel  = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    pc_write      = 1'b0;
    halt          = 1'b0;
    pc_sel        = 2'b00;
    rdv_sel       = 2'b00;
    imm_sel       = 3'b000;
    alu_src_a     = 1'b0;
    alu_src_b     = 1'b0;
    alu_sub_sel   = 2'b00;
    alu_force_add = 1'b0;
    if (state_q inside {S_EXECUTE, S_MEM, S_MEM_WAIT, S_WRITEBACK}) begin
      imm_sel       = ex_imm_sel;
      alu_src_a     = ex_src_a;
      alu_src_b     = ex_src_b;
      alu_sub_sel   = ex_sub_sel;
      alu_force_add = ex_force_add;
    end
    case (state_q)
      S_FETCH: begin
        wait_d  = WAIT_INIT;
        state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (wait_q == 2'd0) begin
          instr_d = bus.mem_read_data;
          state_d = S_DECODE;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_DECODE: state_d = legal ? S_EXECUTE : S_HALT;
      S_EXECUTE: begin
        if (opcode == OPC_BRANCH) begin
          pc_write  = 1'b1;
          pc_sel    = bus.branch_taken ? 2'b01 : 2'b00;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
        end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        mem_addr_sel = 1'b1;
        if (opcode == OPC_STORE) begin
          mem_write = 1'b1;
          pc_write  = 1'b1;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        mem_addr_sel = 1'b1;
        if (wait_q == 2'd0) state_d = S_WRITEBACK;
        else                wait_d  = wait_q - 2'd1;
      end
      S_WRITEBACK: begin
        pc_write  = 1'b1;
        reg_write = rd_nonzero;
        instret_d = instret_q + 32'd1;
        state_d   = S_FETCH;
        case (opcode)
          OPC_LOAD: rdv_sel = 2'b01;
          OPC_JALR: begin
            rdv_sel = 2'b10;
            pc_sel  = 2'b10;
          end
          OPC_JAL: begin
            rdv_sel = 2'b10;
            pc_sel  = 2'b01;
            imm_sel = 3'b010;
          end
          OPC_LUI: begin
            rdv_sel = 2'b11;
            imm_sel = 3'b011;
          end
          default: rdv_sel = 2'b00;
        endcase
      end
      S_HALT:  halt = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // State registers; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instr_q   <= '0;
      instret_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
    end
  end

  assign bus.instr         = instr_q;
  assign bus.instret       = instret_q;
  assign bus.mem_addr_sel  = mem_addr_sel;
  assign bus.mem_write     = mem_write;
  assign bus.reg_write     = reg_write;
  assign bus.pc_write      = pc_write;
  assign bus.pc_sel        = pc_sel;
  assign bus.imm_sel       = imm_sel;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_sub_sel   = alu_sub_sel;
  assign bus.alu_force_add = alu_force_add;
  assign bus.rdv_sel       = rdv_sel;
  assign bus.halt          = halt;
endmodule

// File: tb/tb_rv_control_fsm.sv
// Bench for rv_control_fsm: two instances (L=1 and L=2) sharing stimulus, one observed at a time.
// Fixed vector table, hand-written corner sequences, then random instructions vs a cycle-count model.
module tb_rv_control_fsm;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] mdata;
  logic bt;
  always #5 clk = ~clk;

  rv_control_fsm_if bus1 ();
  rv_control_fsm_if bus2 ();
  assign bus1.mem_read_data = mdata;
  assign bus1.branch_taken  = bt;
  assign bus2.mem_read_data = mdata;
  assign bus2.branch_taken  = bt;

  rv_control_fsm #(.MEM_READ_LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(bus1));
  rv_control_fsm #(.MEM_READ_LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(bus2));

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BR = 7'h63;
  localparam logic [6:0] LD = 7'h03, ST = 7'h23, OPI = 7'h13, OP = 7'h33;

  typedef struct packed { logic pc_write, reg_write, mem_write, mem_addr_sel, halt; } en_t;
  typedef struct packed {
    logic [1:0] pc_sel; logic [1:0] rdv_sel; logic [2:0] imm_sel;
    logic src_a; logic src_b; logic [1:0] sub_sel; logic force_add;
  } sel_t;
  typedef struct {
    logic [31:0] w; logic b; int cyc; logic rw; logic mw;
    logic [1:0] pcs; logic [1:0] rdv; logic [2:0] imm; logic srcb;
  } vec_t;

  int sel = 1;
  en_t o_en;
  sel_t o_sel;
  logic [31:0] o_instret, o_instr;
  always_comb begin
    if (sel == 2) begin
      o_en  = {bus2.pc_write, bus2.reg_write, bus2.mem_write, bus2.mem_addr_sel, bus2.halt};
      o_sel = {bus2.pc_sel, bus2.rdv_sel, bus2.imm_sel, bus2.alu_src_a, bus2.alu_src_b,
               bus2.alu_sub_sel, bus2.alu_force_add};
      o_instret = bus2.instret;
      o_instr   = bus2.instr;
    end else begin
      o_en  = {bus1.pc_write, bus1.reg_write, bus1.mem_write, bus1.mem_addr_sel, bus1.halt};
      o_sel = {bus1.pc_sel, bus1.rdv_sel, bus1.imm_sel, bus1.alu_src_a, bus1.alu_src_b,
               bus1.alu_sub_sel, bus1.alu_force_add};
      o_instret = bus1.instret;
      o_instr   = bus1.instr;
    end
  end

  int checks = 0;
  int failures = 0;
  int exp_ic = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Total cycles an instruction occupies, counted from its FETCH cycle (=1).
  function automatic int n_cycles(logic [31:0] w, int L);
    if (w[6:0] == BR) return L + 3;
    if (w[6:0] == LD) return 2 * L + 5;
    return L + 4;
  endfunction

  // Enables expected in cycle k: retirement happens only in the last cycle.
  function automatic en_t exp_en(logic [31:0] w, int L, int k);
    en_t e;
    logic ret;
    e = '0;
    ret = (k == n_cycles(w, L));
    e.pc_write  = ret;
    e.reg_write = ret && (w[6:0] != BR) && (w[6:0] != ST) && (w[11:7] != 5'd0);
    e.mem_write = ret && (w[6:0] == ST);
    if (w[6:0] == LD) e.mem_addr_sel = (k >= L + 4) && (k <= 2 * L + 4);
    else              e.mem_addr_sel = ret && (w[6:0] == ST);
    return e;
  endfunction

  // Selects expected in the retiring cycle, straight from the opcode table.
  function automatic sel_t exp_sel(logic [31:0] w, logic b);
    sel_t s;
    logic [2:0] f3;
    logic [1:0] fs;
    s  = '0;
    f3 = w[14:12];
    if (f3 == 3'b001 || f3 == 3'b101)      fs = 2'b10;
    else if (f3 == 3'b010 || f3 == 3'b011) fs = 2'b01;
    else                                   fs = 2'b00;
    case (w[6:0])
      OP:  s.sub_sel = fs;
      OPI: begin
        s.sub_sel = fs; s.src_b = 1'b1;
        s.imm_sel = (f3 == 3'b001 || f3 == 3'b101) ? 3'b001 : 3'b000;
      end
      LD:    begin s.force_add = 1'b1; s.src_b = 1'b1; s.rdv_sel = 2'b01; end
      ST:    begin s.force_add = 1'b1; s.src_b = 1'b1; s.imm_sel = 3'b101; end
      AUIPC: begin s.src_a = 1'b1; s.src_b = 1'b1; s.imm_sel = 3'b011; s.force_add = 1'b1; end
      JALR:  begin s.force_add = 1'b1; s.src_b = 1'b1; s.rdv_sel = 2'b10; s.pc_sel = 2'b10; end
      BR:    begin s.sub_sel = 2'b01; s.imm_sel = 3'b100; s.pc_sel = b ? 2'b01 : 2'b00; end
      LUI:   begin s.imm_sel = 3'b011; s.rdv_sel = 2'b11; end
      JAL:   begin s.imm_sel = 3'b010; s.rdv_sel = 2'b10; s.pc_sel = 2'b01; end
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset enables", 32'(o_en), 32'h0);
    check("reset selects", 32'(o_sel), 32'h0);
    check("reset instret", o_instret, 32'h0);
    check("reset instr", o_instr, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_ic = 0;
  endtask

  task automatic run_instr(input logic [31:0] w, input logic b, input int L, input int id);
    int n;
    n = n_cycles(w, L);
    mdata = w;
    bt = b;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) check($sformatf("rnd%0d instret", id), o_instret, 32'(exp_ic));
      check($sformatf("rnd%0d w=%h c%0d enables", id, w, k), 32'(o_en), 32'(exp_en(w, L, k)));
      if (k == n) begin
        check($sformatf("rnd%0d w=%h selects", id, w), 32'(o_sel), 32'(exp_sel(w, b)));
        check($sformatf("rnd%0d instr", id), o_instr, w);
      end
    end
    exp_ic++;
  endtask

  task automatic run_halt(input logic [31:0] w, input string tag);
    mdata = w;
    bt = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      check($sformatf("%s c%0d enables/halt", tag, k), 32'(o_en), {31'b0, k >= 4});
    end
    check($sformatf("%s instret", tag), o_instret, 32'(exp_ic));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  vec_t tbl[11];
  logic [6:0] opcs[9];

  initial begin
    tbl[0]  = '{32'h00500093, 1'b0, 5, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1}; // ADDI x1,x0,5
    tbl[1]  = '{32'h00000463, 1'b1, 4, 1'b0, 1'b0, 2'b01, 2'b00, 3'b100, 1'b0}; // BEQ taken
    tbl[2]  = '{32'h00000463, 1'b0, 4, 1'b0, 1'b0, 2'b00, 2'b00, 3'b100, 1'b0}; // BEQ not taken
    tbl[3]  = '{32'h00208033, 1'b0, 5, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0}; // ADD x0,x1,x2
    tbl[4]  = '{32'h0020A423, 1'b0, 5, 1'b0, 1'b1, 2'b00, 2'b00, 3'b101, 1'b1}; // SW
    tbl[5]  = '{32'h123452B7, 1'b0, 5, 1'b1, 1'b0, 2'b00, 2'b11, 3'b011, 1'b0}; // LUI
    tbl[6]  = '{32'h010000EF, 1'b0, 5, 1'b1, 1'b0, 2'b01, 2'b10, 3'b010, 1'b0}; // JAL
    tbl[7]  = '{32'h00008067, 1'b0, 5, 1'b0, 1'b0, 2'b10, 2'b10, 3'b000, 1'b1}; // JALR x0
    tbl[8]  = '{32'h00001197, 1'b0, 5, 1'b1, 1'b0, 2'b00, 2'b00, 3'b011, 1'b1}; // AUIPC
    tbl[9]  = '{32'h0040A103, 1'b0, 7, 1'b1, 1'b0, 2'b00, 2'b01, 3'b000, 1'b1}; // LW at L=1
    tbl[10] = '{32'h00209193, 1'b0, 5, 1'b1, 1'b0, 2'b00, 2'b00, 3'b001, 1'b1}; // SLLI
    opcs = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OP};
    mdata = 32'h0;
    bt = 1'b0;
    reset = 1'b1;

    // Vector table on the L=1 instance.
    sel = 1;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      mdata = tbl[i].w;
      bt = tbl[i].b;
      for (int k = 1; k <= tbl[i].cyc; k++) begin
        @(negedge clk);
        if (k == 1) check($sformatf("vec%0d instret", i), o_instret, 32'(exp_ic));
        check($sformatf("vec%0d c%0d pw/rw/mw/halt", i, k),
              {28'b0, o_en.pc_write, o_en.reg_write, o_en.mem_write, o_en.halt},
              {28'b0, k == tbl[i].cyc, (k == tbl[i].cyc) && tbl[i].rw,
               (k == tbl[i].cyc) && tbl[i].mw, 1'b0});
        if (k == tbl[i].cyc)
          check($sformatf("vec%0d pc_sel/rdv_sel/imm_sel/src_b", i),
                {24'b0, o_sel.pc_sel, o_sel.rdv_sel, o_sel.imm_sel, o_sel.src_b},
                {24'b0, tbl[i].pcs, tbl[i].rdv, tbl[i].imm, tbl[i].srcb});
      end
      exp_ic++;
    end

    // Random legal instructions at L=1.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = opcs[$urandom_range(0, 8)];
      run_instr(w, 1'($urandom_range(0, 1)), 1, i);
    end

    // Illegal opcode halts with instret frozen; then ECALL after a reset.
    run_halt(32'h00000000, "halt_zero");
    do_reset();
    run_instr(32'h00500093, 1'b0, 1, 100);
    run_halt(32'h00000073, "halt_ecall");

    // LW at L=2: address mux held through MEM and both MEM_WAIT cycles.
    sel = 2;
    do_reset();
    mdata = 32'h0040A103;
    bt = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("lw_l2 c%0d mas/mw/rw/pw", k),
            {28'b0, o_en.mem_addr_sel, o_en.mem_write, o_en.reg_write, o_en.pc_write},
            {28'b0, k >= 6 && k <= 8, 1'b0, k == 9, k == 9});
      if (k == 9) check("lw_l2 rdv_sel", 32'(o_sel.rdv_sel), 32'h1);
    end
    exp_ic++;

    // Random legal instructions at L=2.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = opcs[$urandom_range(0, 8)];
      run_instr(w, 1'($urandom_range(0, 1)), 2, 200 + i);
    end

    // Reset landing on a store's MEM cycle abandons it.
    sel = 1;
    do_reset();
    run_instr(32'h00500093, 1'b0, 1, 300);
    mdata = 32'h0020A423;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("sw_rst c%0d enables", k), 32'(o_en), 32'(exp_en(32'h0020A423, 1, k)));
    end
    @(negedge clk);
    check("sw_rst mem_write in MEM", {30'b0, o_en.mem_write, o_en.pc_write}, 32'h3);
    reset = 1'b1;
    @(negedge clk);
    check("sw_rst enables after reset", 32'(o_en), 32'h0);
    check("sw_rst instret after reset", o_instret, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_ic = 0;
    run_instr(32'h00500093, 1'b0, 1, 301);
    @(negedge clk);
    check("final instret", o_instret, 32'(exp_ic));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
